// File: rtl/video_text_writer_pkg.sv
// Shared constants and types for the text console writer: ASCII control codes,
// FSM state encoding and cursor command encoding.
package video_text_writer_pkg;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LINE_CLR = 2'd1,
        ST_SCR_CLR  = 2'd2
    } wr_state_t;

    typedef enum logic [2:0] {
        CUR_NOP     = 3'd0,
        CUR_INC     = 3'd1,
        CUR_NEWLINE = 3'd2,
        CUR_CR      = 3'd3,
        CUR_BACK    = 3'd4,
        CUR_HOME    = 3'd5
    } cur_cmd_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/video_text_writer_if.sv
// Byte-stream input and RAM write port of the text console writer.
interface video_text_writer_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
);
    logic [7:0]            char_in;
    logic                  char_valid;
    logic                  char_ready;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  write_en;

    modport slave (
        input  char_in, char_valid,
        output char_ready, waddr, wdata, write_en
    );

    modport master (
        output char_in, char_valid,
        input  char_ready, waddr, wdata, write_en
    );
endinterface

// File: rtl/video_cursor.sv
// Cursor position tracker: column, row and the row's base address (row*COLS)
// kept as an accumulated register so no multiplier is needed.
module video_cursor
    import video_text_writer_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int ROWS       = 76,
    parameter int ADDR_WIDTH = 13,
    parameter int COL_W      = $clog2(COLS),
    parameter int ROW_W      = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  cur_cmd_t              cmd,
    output logic [COL_W-1:0]      col,
    output logic [ROW_W-1:0]      row,
    output logic [ADDR_WIDTH-1:0] line_base,
    output logic                  last_col
);

    logic last_row;
    logic advance;

    assign last_col = (col == COL_W'(COLS - 1));
    assign last_row = (row == ROW_W'(ROWS - 1));
    assign advance  = (cmd == CUR_NEWLINE) || ((cmd == CUR_INC) && last_col);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col       <= '0;
            row       <= '0;
            line_base <= '0;
        end else if (cmd == CUR_HOME) begin
            col       <= '0;
            row       <= '0;
            line_base <= '0;
        end else if (advance) begin
            col <= '0;
            // no scrolling: the bottom row wraps back to the top
            if (last_row) begin
                row       <= '0;
                line_base <= '0;
            end else begin
                row       <= row + 1'b1;
                line_base <= line_base + ADDR_WIDTH'(COLS);
            end
        end else begin
            case (cmd)
                CUR_INC:  col <= col + 1'b1;
                CUR_CR:   col <= '0;
                CUR_BACK: if (col != '0) col <= col - 1'b1;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/video_text_writer.sv
// Console front end: decodes an ASCII byte stream into text RAM writes with
// cursor tracking, line wrap and line/screen clears.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | accepting bytes; printable/BS writes issued from here
//   ST_LINE_CLR | writing FILL_CHAR across the newly entered row
//   ST_SCR_CLR  | writing FILL_CHAR across the whole screen
module video_text_writer
    import video_text_writer_pkg::*;
#(
    parameter int                   COLS       = 80,
    parameter int                   ROWS       = 76,
    parameter int                   ADDR_WIDTH = 13,
    parameter int                   DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_CHAR = DATA_WIDTH'(8'h20)
) (
    input  logic                       clk,
    input  logic                       rstn,
    video_text_writer_if.slave         bus,
    output logic [$clog2(COLS)-1:0]    cursor_col,
    output logic [$clog2(ROWS)-1:0]    cursor_row,
    output logic                       busy
);

    localparam int                    COL_W     = $clog2(COLS);
    localparam int                    ROW_W     = $clog2(ROWS);
    localparam logic [ADDR_WIDTH-1:0] LINE_LAST = ADDR_WIDTH'(COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] SCR_LAST  = ADDR_WIDTH'(COLS * ROWS - 1);

    wr_state_t             state, state_nxt;
    cur_cmd_t              cur_cmd;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] col_ext;
    logic                  last_col;
    logic                  wr_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;

    video_cursor #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .COL_W      (COL_W),
        .ROW_W      (ROW_W)
    ) u_cursor (
        .clk       (clk),
        .rstn      (rstn),
        .cmd       (cur_cmd),
        .col       (cursor_col),
        .row       (cursor_row),
        .line_base (line_base),
        .last_col  (last_col)
    );

    assign col_ext        = ADDR_WIDTH'(cursor_col);
    assign bus.char_ready = (state == ST_IDLE);
    assign busy           = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == ST_IDLE) ? '0 : clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cur_cmd   = CUR_NOP;
        wr_nxt    = 1'b0;
        addr_nxt  = '0;
        data_nxt  = '0;
        case (state)
            ST_IDLE: begin
                if (bus.char_valid) begin
                    if (is_printable(bus.char_in)) begin
                        wr_nxt   = 1'b1;
                        addr_nxt = line_base + col_ext;
                        data_nxt = DATA_WIDTH'(bus.char_in);
                        cur_cmd  = CUR_INC;
                        if (last_col) state_nxt = ST_LINE_CLR;
                    end else begin
                        case (bus.char_in)
                            ASCII_CR: cur_cmd = CUR_CR;
                            ASCII_LF: begin
                                cur_cmd   = CUR_NEWLINE;
                                state_nxt = ST_LINE_CLR;
                            end
                            ASCII_BS: begin
                                if (cursor_col != '0) begin
                                    cur_cmd  = CUR_BACK;
                                    wr_nxt   = 1'b1;
                                    addr_nxt = line_base + col_ext - ADDR_WIDTH'(1);
                                    data_nxt = FILL_CHAR;
                                end
                            end
                            ASCII_FF: begin
                                cur_cmd   = CUR_HOME;
                                state_nxt = ST_SCR_CLR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_LINE_CLR: begin
                // cursor already points at the new row, so line_base is its start
                wr_nxt   = 1'b1;
                addr_nxt = line_base + clr_cnt;
                data_nxt = FILL_CHAR;
                if (clr_cnt == LINE_LAST) state_nxt = ST_IDLE;
            end
            ST_SCR_CLR: begin
                wr_nxt   = 1'b1;
                addr_nxt = clr_cnt;
                data_nxt = FILL_CHAR;
                if (clr_cnt == SCR_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.write_en <= 1'b0;
            bus.waddr    <= '0;
            bus.wdata    <= '0;
        end else begin
            bus.write_en <= wr_nxt;
            if (wr_nxt) begin
                bus.waddr <= addr_nxt;
                bus.wdata <= data_nxt;
            end
        end
    end

endmodule
